// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Registered response channel tagged with the winning requester's ID.
module alu_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [3:0]        alu_flags,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [WIDTH-1:0]  resp_result,
  output logic [3:0]        resp_flags
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt;
  logic           found;
  logic           grant;
  logic           slot_free;

  assign slot_free = !resp_valid || resp_ready;

  // Search starts at rr_ptr and wraps around to rr_ptr-1.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  assign grant = found && slot_free && !rst;

  always_comb begin
    req_ready   = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 3'b000;
    if (grant) begin
      req_ready   = NREQ'(1) << gnt;
      alu_a       = req_a[gnt*WIDTH +: WIDTH];
      alu_b       = req_b[gnt*WIDTH +: WIDTH];
      alu_control = req_op[gnt*3 +: 3];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
      rr_ptr      <= '0;
    end else if (grant) begin
      resp_valid  <= 1'b1;
      resp_id     <= gnt;
      resp_result <= alu_result;
      resp_flags  <= alu_flags;
      rr_ptr      <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
    end else if (resp_valid && resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter with a behavioural ALU.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_alu_rr_arbiter;

  localparam int W  = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR*3-1:0] req_op;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [2:0]      alu_control;
  logic [W-1:0]    alu_result;
  logic [3:0]      alu_flags;
  logic            resp_valid;
  logic            resp_ready;
  logic [IW-1:0]   resp_id;
  logic [W-1:0]    resp_result;
  logic [3:0]      resp_flags;

  int compared;
  int mismatched;

  alu_rr_arbiter #(.WIDTH(W), .NREQ(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_flags  (resp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {n,z,c,v,result}
  function automatic logic [35:0] alu_model(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a << b[4:0];
      3'b101: r = a >> b[4:0];
      3'b110: r = a ^ b;
      default: r = ~a;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb begin
    logic [35:0] m;
    m = alu_model(alu_a, alu_b, alu_control);
    alu_result = m[31:0];
    alu_flags  = m[35:32];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rr_exp [4];
  logic [35:0] m;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;

    tick();
    tick();
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_result", 64'(resp_result), 64'd0);
    chk("rst_resp_flags", 64'(resp_flags), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    rst       = 1'b0;
    req_valid = 4'b0000;
    tick();

    // Single add on requester 0
    set_req(0, 32'd5, 32'd3, 3'b000);
    req_valid = 4'b0001;
    #1;
    chk("single_req_ready", 64'(req_ready), 64'b0001);
    chk("single_alu_a", 64'(alu_a), 64'd5);
    tick();
    req_valid = 4'b0000;
    chk("single_resp_valid", 64'(resp_valid), 64'd1);
    chk("single_resp_id", 64'(resp_id), 64'd0);
    chk("single_resp_result", 64'(resp_result), 64'd8);
    chk("single_resp_flags", 64'(resp_flags), 64'b0000);
    tick();
    chk("drain_resp_valid", 64'(resp_valid), 64'd0);

    // Subtract on requester 2; pointer sits at 1
    set_req(2, 32'd3, 32'd5, 3'b001);
    req_valid = 4'b0100;
    #1;
    chk("sub_req_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'b0000;
    m = alu_model(32'd3, 32'd5, 3'b001);
    chk("sub_resp_id", 64'(resp_id), 64'd2);
    chk("sub_resp_result", 64'(resp_result), 64'hFFFF_FFFE);
    chk("sub_flag_n", 64'(resp_flags[3]), 64'd1);
    chk("sub_flag_z", 64'(resp_flags[2]), 64'd0);
    chk("sub_flags_model", 64'(resp_flags), 64'(m[35:32]));
    tick();

    // Short reset between edges returns the pointer to 0
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick();

    set_req(0, 32'd10, 32'd20, 3'b000);
    set_req(1, 32'd100, 32'd1, 3'b001);
    set_req(2, 32'hF0, 32'h3C, 3'b010);
    set_req(3, 32'd1, 32'd4, 3'b100);
    rr_exp[0] = 32'd30;
    rr_exp[1] = 32'd99;
    rr_exp[2] = 32'h30;
    rr_exp[3] = 32'd16;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(4'b0001 << (i % 4)));
      tick();
      chk($sformatf("rr_id_%0d", i), 64'(resp_id), 64'(i % 4));
      chk($sformatf("rr_result_%0d", i), 64'(resp_result), 64'(rr_exp[i % 4]));
    end

    // Back-pressure: response from requester 3 held
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i), 64'(req_ready), 64'd0);
      tick();
      chk($sformatf("bp_valid_%0d", i), 64'(resp_valid), 64'd1);
      chk($sformatf("bp_id_%0d", i), 64'(resp_id), 64'd3);
      chk($sformatf("bp_result_%0d", i), 64'(resp_result), 64'd16);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'b0001);
    tick();
    chk("bp_release_valid", 64'(resp_valid), 64'd1);
    chk("bp_release_id", 64'(resp_id), 64'd0);
    chk("bp_release_result", 64'(resp_result), 64'd30);

    // Pointer at 1 with requesters 0 and 3 valid
    req_valid = 4'b1001;
    #1;
    chk("skip_ready_3", 64'(req_ready), 64'b1000);
    tick();
    chk("skip_id_3", 64'(resp_id), 64'd3);
    chk("skip_result_3", 64'(resp_result), 64'd16);
    #1;
    chk("skip_ready_0", 64'(req_ready), 64'b0001);
    tick();
    chk("skip_id_0", 64'(resp_id), 64'd0);
    chk("skip_valid", 64'(resp_valid), 64'd1);

    // Asynchronous reset between edges with a pending response
    #3 rst = 1'b1;
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_resp_result", 64'(resp_result), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    #2 rst = 1'b0;
    req_valid = 4'b1110;
    #1;
    chk("arst_first_ready", 64'(req_ready), 64'b0010);
    tick();
    chk("arst_first_id", 64'(resp_id), 64'd1);
    chk("arst_first_result", 64'(resp_result), 64'd99);
    req_valid = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
